// File: rtl/note_gfx_pkg.sv
// Shared constants and types for the note-sprite renderer.
// Build option: define SPRITE_BORDER_EN to draw a 1-px outline around enabled sprite boxes.
package note_gfx_pkg;

    localparam int unsigned DEF_SPRITE_WIDTH    = 8;
    localparam int unsigned DEF_SPRITE_HEIGHT   = 8;
    localparam int unsigned DEF_NUM_SPRITES     = 8;
    localparam int unsigned DEF_NUM_SLOTS       = 8;
    localparam int unsigned DEF_SCALE_LOG2      = 2;
    localparam int unsigned DEF_SLOT_PITCH_LOG2 = 6;
    localparam int unsigned DEF_ORIGIN_X        = 64;
    localparam int unsigned DEF_ORIGIN_Y        = 200;
    localparam int unsigned DEF_H_BITS          = 10;
    localparam int unsigned DEF_V_BITS          = 10;

    localparam int unsigned SPRITE_IDX_W = $clog2(DEF_NUM_SPRITES);
    localparam int unsigned SLOT_IDX_W   = $clog2(DEF_NUM_SLOTS);
    localparam int unsigned ADDR_W       =
        $clog2(DEF_NUM_SPRITES * DEF_SPRITE_WIDTH * DEF_SPRITE_HEIGHT);
    localparam int unsigned RGB_W        = 12;

    localparam logic [RGB_W-1:0] DEF_FG_COLOR     = 12'hFFF;
    localparam logic [RGB_W-1:0] DEF_BG_COLOR     = 12'h000;
    localparam logic [RGB_W-1:0] DEF_BORDER_COLOR = 12'hF00;

    typedef struct packed {
        logic                    en;
        logic [SPRITE_IDX_W-1:0] sprite;
    } slot_t;

endpackage

// File: rtl/note_slot_table.sv
// Double-buffered slot table: writes land in a shadow copy that is committed to the
// active copy on the cycle after a vsync rising edge, so a frame never changes mid-scan.
module note_slot_table
    import note_gfx_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
    localparam int unsigned SLOT_B   = $clog2(NUM_SLOTS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vsync,
    input  logic                       slot_we,
    input  logic [SLOT_B-1:0]          slot_idx,
    input  logic [SPRITE_IDX_W-1:0]    slot_sprite,
    input  logic                       slot_en,
    output logic                       slot_ready,
    output slot_t [NUM_SLOTS-1:0]      active_tbl
);

    logic                  vsync_q;
    logic                  commit_q;
    logic                  ready_q;
    slot_t [NUM_SLOTS-1:0] shadow_q;
    slot_t [NUM_SLOTS-1:0] active_q;

    // Writes are refused during the commit cycle so the copy sees a stable shadow.
    assign slot_ready = ready_q & ~commit_q;
    assign active_tbl = active_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q  <= 1'b0;
            commit_q <= 1'b0;
            ready_q  <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            vsync_q  <= vsync;
            commit_q <= vsync & ~vsync_q;
            ready_q  <= 1'b1;
            if (slot_we && slot_ready) begin
                shadow_q[slot_idx] <= slot_t'{en: slot_en, sprite: slot_sprite};
            end
            if (commit_q) begin
                active_q <= shadow_q;
            end
        end
    end

endmodule

// File: rtl/note_sprite_renderer.sv
// Renders a row of note sprites from a 1-bit bitmap memory with a fixed 3-cycle latency.
// Build option: SPRITE_BORDER_EN adds a BORDER_COLOR outline around each enabled sprite box.
module note_sprite_renderer
    import note_gfx_pkg::*;
#(
    parameter int unsigned SPRITE_WIDTH    = DEF_SPRITE_WIDTH,
    parameter int unsigned SPRITE_HEIGHT   = DEF_SPRITE_HEIGHT,
    parameter int unsigned NUM_SPRITES     = DEF_NUM_SPRITES,
    parameter int unsigned NUM_SLOTS       = DEF_NUM_SLOTS,
    parameter int unsigned SCALE_LOG2      = DEF_SCALE_LOG2,
    parameter int unsigned SLOT_PITCH_LOG2 = DEF_SLOT_PITCH_LOG2,
    parameter int unsigned ORIGIN_X        = DEF_ORIGIN_X,
    parameter int unsigned ORIGIN_Y        = DEF_ORIGIN_Y,
    parameter int unsigned H_BITS          = DEF_H_BITS,
    parameter int unsigned V_BITS          = DEF_V_BITS,
    parameter logic [11:0] FG_COLOR        = DEF_FG_COLOR,
    parameter logic [11:0] BG_COLOR        = DEF_BG_COLOR
`ifdef SPRITE_BORDER_EN
    ,
    parameter logic [11:0] BORDER_COLOR    = DEF_BORDER_COLOR
`endif
) (
    input  logic                                                     clk,
    input  logic                                                     reset,
    input  logic [H_BITS-1:0]                                        pix_x,
    input  logic [V_BITS-1:0]                                        pix_y,
    input  logic                                                     pix_active,
    input  logic                                                     pix_hsync,
    input  logic                                                     pix_vsync,
    input  logic                                                     slot_we,
    input  logic [$clog2(NUM_SLOTS)-1:0]                             slot_idx,
    input  logic [$clog2(NUM_SPRITES)-1:0]                           slot_sprite,
    input  logic                                                     slot_en,
    output logic                                                     slot_ready,
    output logic [$clog2(NUM_SPRITES*SPRITE_WIDTH*SPRITE_HEIGHT)-1:0] mem_rd_addr,
    input  logic                                                     mem_data,
    output logic [11:0]                                              rgb,
    output logic                                                     out_hsync,
    output logic                                                     out_vsync,
    output logic                                                     out_active
);

    localparam int unsigned COL_B   = $clog2(SPRITE_WIDTH);
    localparam int unsigned ROW_B   = $clog2(SPRITE_HEIGHT);
    localparam int unsigned SLOT_B  = $clog2(NUM_SLOTS);
    localparam int unsigned A_W     = $clog2(NUM_SPRITES * SPRITE_WIDTH * SPRITE_HEIGHT);
    localparam int unsigned SLOTN_W = H_BITS - SLOT_PITCH_LOG2;
    localparam int unsigned OFF_W   = SLOT_PITCH_LOG2 + 1;
    localparam int unsigned BOX_W   = SPRITE_WIDTH << SCALE_LOG2;
    localparam int unsigned BOX_H   = SPRITE_HEIGHT << SCALE_LOG2;

    slot_t [NUM_SLOTS-1:0] active_tbl;

    note_slot_table #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_slot_table (
        .clk         (clk),
        .reset       (reset),
        .vsync       (pix_vsync),
        .slot_we     (slot_we),
        .slot_idx    (slot_idx),
        .slot_sprite (slot_sprite),
        .slot_en     (slot_en),
        .slot_ready  (slot_ready),
        .active_tbl  (active_tbl)
    );

    logic [H_BITS-1:0]          rx;
    logic [V_BITS-1:0]          ry;
    logic [SLOTN_W-1:0]         slot_raw;
    logic [SLOT_PITCH_LOG2-1:0] off;
    logic [COL_B-1:0]           col;
    logic [ROW_B-1:0]           row;
    slot_t                      ent;
    logic                       hit_d;
    logic [A_W-1:0]             addr_d;

    // Origin compares are done on the raw coordinates so the subtraction never wraps into a hit.
    always_comb begin
        rx       = pix_x - H_BITS'(ORIGIN_X);
        ry       = pix_y - V_BITS'(ORIGIN_Y);
        slot_raw = rx[H_BITS-1:SLOT_PITCH_LOG2];
        off      = rx[SLOT_PITCH_LOG2-1:0];
        ent      = active_tbl[slot_raw[SLOT_B-1:0]];
        col      = off[SCALE_LOG2 +: COL_B];
        row      = ry[SCALE_LOG2 +: ROW_B];
        hit_d    = pix_active
                 && (pix_x >= H_BITS'(ORIGIN_X))
                 && (pix_y >= V_BITS'(ORIGIN_Y))
                 && (slot_raw < SLOTN_W'(NUM_SLOTS))
                 && ({1'b0, off} < OFF_W'(BOX_W))
                 && (ry < V_BITS'(BOX_H))
                 && ent.en;
        addr_d   = hit_d ? {ent.sprite, row, col} : '0;
    end

`ifdef SPRITE_BORDER_EN
    logic border_d;
    logic border1_q;
    logic border2_q;

    always_comb begin
        border_d = hit_d && ((off == '0) || ({1'b0, off} == OFF_W'(BOX_W - 1))
                          || (ry == '0) || (ry == V_BITS'(BOX_H - 1)));
    end
`endif

    logic        v1_q, hit1_q, act1_q, hs1_q, vs1_q;
    logic        v2_q, hit2_q, act2_q, hs2_q, vs2_q;
    logic [11:0] rgb_d;

    always_comb begin
        rgb_d = '0;
        if (v2_q && act2_q) begin
            rgb_d = (hit2_q && mem_data) ? FG_COLOR : BG_COLOR;
`ifdef SPRITE_BORDER_EN
            if (border2_q) rgb_d = BORDER_COLOR;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q        <= 1'b0;
            hit1_q      <= 1'b0;
            act1_q      <= 1'b0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            mem_rd_addr <= '0;
            v2_q        <= 1'b0;
            hit2_q      <= 1'b0;
            act2_q      <= 1'b0;
            hs2_q       <= 1'b0;
            vs2_q       <= 1'b0;
            rgb         <= '0;
            out_hsync   <= 1'b0;
            out_vsync   <= 1'b0;
            out_active  <= 1'b0;
        end else begin
            v1_q        <= 1'b1;
            hit1_q      <= hit_d;
            act1_q      <= pix_active;
            hs1_q       <= pix_hsync;
            vs1_q       <= pix_vsync;
            mem_rd_addr <= addr_d;
            v2_q        <= v1_q;
            hit2_q      <= hit1_q;
            act2_q      <= act1_q;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
            rgb         <= rgb_d;
            out_hsync   <= v2_q & hs2_q;
            out_vsync   <= v2_q & vs2_q;
            out_active  <= v2_q & act2_q;
        end
    end

`ifdef SPRITE_BORDER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            border1_q <= 1'b0;
            border2_q <= 1'b0;
        end else begin
            border1_q <= border_d;
            border2_q <= border1_q;
        end
    end
`endif

endmodule

// File: tb/tb_note_sprite_renderer.sv
// Directed bench for note_sprite_renderer with a registered 1-bit bitmap memory model.
module tb_note_sprite_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pix_x, pix_y;
    logic        pix_active, pix_hsync, pix_vsync;
    logic        slot_we, slot_en, slot_ready;
    logic [2:0]  slot_idx, slot_sprite;
    logic [8:0]  mem_rd_addr;
    logic        mem_data;
    logic [11:0] rgb;
    logic        out_hsync, out_vsync, out_active;

    logic        mem_bits [0:511];
    int          n_tests = 0;
    int          n_fail  = 0;

`ifdef SPRITE_BORDER_EN
    localparam logic [11:0] EDGE_FG = 12'hF00;
`else
    localparam logic [11:0] EDGE_FG = 12'hFFF;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= mem_bits[mem_rd_addr];

    note_sprite_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_active  (pix_active),
        .pix_hsync   (pix_hsync),
        .pix_vsync   (pix_vsync),
        .slot_we     (slot_we),
        .slot_idx    (slot_idx),
        .slot_sprite (slot_sprite),
        .slot_en     (slot_en),
        .slot_ready  (slot_ready),
        .mem_rd_addr (mem_rd_addr),
        .mem_data    (mem_data),
        .rgb         (rgb),
        .out_hsync   (out_hsync),
        .out_vsync   (out_vsync),
        .out_active  (out_active)
    );

    // One active pixel with hsync high, then idle; returns address one cycle later and
    // colour/sync three cycles after the sampling edge.
    task automatic run_pixel(input logic [9:0] x, input logic [9:0] y, output logic [8:0] a,
                             output logic [11:0] c, output logic act, output logic hs);
        @(negedge clk);
        pix_x = x; pix_y = y; pix_active = 1'b1; pix_hsync = 1'b1;
        @(posedge clk); #1;
        a = mem_rd_addr;
        @(negedge clk);
        pix_x = '0; pix_y = '0; pix_active = 1'b0; pix_hsync = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        c = rgb; act = out_active; hs = out_hsync;
    endtask

    task automatic write_slot(input logic [2:0] idx, input logic [2:0] spr, input logic en);
        @(negedge clk);
        slot_we = 1'b1; slot_idx = idx; slot_sprite = spr; slot_en = en;
        @(negedge clk);
        slot_we = 1'b0;
    endtask

    task automatic pulse_vsync();
        @(negedge clk); pix_vsync = 1'b1;
        repeat (3) @(negedge clk);
        pix_vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [8:0] a; logic [11:0] c; logic act, hs;
        reset = 1'b0; pix_active = 1'b1; pix_hsync = 1'b1; pix_vsync = 1'b1;
        pix_x = 10'd64; pix_y = 10'd200;
        repeat (3) @(posedge clk); #1;
        n_tests++;
        if ({rgb, out_hsync, out_vsync, out_active, slot_ready, mem_rd_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rgb=%h hs=%b vs=%b act=%b rdy=%b addr=%0d want all 0",
                     rgb, out_hsync, out_vsync, out_active, slot_ready, mem_rd_addr);
        end
        // release mid-line: active stays high, vsync low so no commit follows
        @(negedge clk);
        pix_vsync = 1'b0; pix_x = '0; pix_y = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (slot_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_release: got %b want 1", slot_ready);
        end
        n_tests++;
        if (out_active !== 1'b0) begin
            n_fail++; $display("FAIL fill_stage1: out_active got %b want 0", out_active);
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_active !== 1'b0 || out_hsync !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_stage2: act=%b hs=%b want 0 0", out_active, out_hsync);
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_active !== 1'b1 || out_hsync !== 1'b1 || rgb !== 12'h000) begin
            n_fail++;
            $display("FAIL fill_stage3: act=%b hs=%b rgb=%h want 1 1 000", out_active, out_hsync,
                     rgb);
        end
        @(negedge clk); pix_active = 1'b0; pix_hsync = 1'b0;
        run_pixel(10'd64, 10'd200, a, c, act, hs);
        n_tests++;
        if (a !== 9'd0 || c !== 12'h000 || act !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_frame: addr=%0d rgb=%h act=%b want 0 000 1", a, c, act);
        end
    endtask

    task automatic test_slot_write();
        logic [8:0] a; logic [11:0] c; logic act, hs;
        write_slot(3'd0, 3'd2, 1'b1);
        run_pixel(10'd64, 10'd200, a, c, act, hs);
        n_tests++;
        if (a !== 9'd0 || c !== 12'h000) begin
            n_fail++; $display("FAIL before_commit: addr=%0d rgb=%h want 0 000", a, c);
        end
        pulse_vsync();
        run_pixel(10'd64, 10'd200, a, c, act, hs);
        n_tests++;
        if (a !== 9'd128) begin
            n_fail++; $display("FAIL slot0_addr: got %0d want 128", a);
        end
        n_tests++;
        if (c !== EDGE_FG || act !== 1'b1 || hs !== 1'b1) begin
            n_fail++;
            $display("FAIL slot0_rgb: rgb=%h act=%b hs=%b want %h 1 1", c, act, hs, EDGE_FG);
        end
    endtask

    task automatic test_column_edge();
        logic [8:0] a; logic [11:0] c; logic act, hs;
        run_pixel(10'd95, 10'd200, a, c, act, hs);
        n_tests++;
        if (a !== 9'd135 || c !== EDGE_FG) begin
            n_fail++; $display("FAIL col7: addr=%0d rgb=%h want 135 %h", a, c, EDGE_FG);
        end
        run_pixel(10'd96, 10'd200, a, c, act, hs);
        n_tests++;
        if (a !== 9'd0 || c !== 12'h000 || act !== 1'b1) begin
            n_fail++; $display("FAIL col_past: addr=%0d rgb=%h act=%b want 0 000 1", a, c, act);
        end
        run_pixel(10'd77, 10'd220, a, c, act, hs);
        n_tests++;
        if (a !== 9'd171 || c !== 12'hFFF) begin
            n_fail++; $display("FAIL interior: addr=%0d rgb=%h want 171 fff", a, c);
        end
    endtask

    task automatic test_boundaries();
        logic [8:0] a; logic [11:0] c; logic act, hs;
        logic [9:0] xs [4];
        logic [9:0] ys [4];
        xs = '{10'd64, 10'd64, 10'd63, 10'd576};
        ys = '{10'd199, 10'd232, 10'd200, 10'd200};
        for (int i = 0; i < 4; i++) begin
            run_pixel(xs[i], ys[i], a, c, act, hs);
            n_tests++;
            if (a !== 9'd0 || c !== 12'h000 || act !== 1'b1) begin
                n_fail++;
                $display("FAIL boundary_%0d: (%0d,%0d) addr=%0d rgb=%h act=%b want 0 000 1",
                         i, xs[i], ys[i], a, c, act);
            end
        end
    endtask

    task automatic test_commit_write();
        logic [8:0] a; logic [11:0] c; logic act, hs;
        @(negedge clk); pix_vsync = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (slot_ready !== 1'b0) begin
            n_fail++; $display("FAIL commit_ready: got %b want 0", slot_ready);
        end
        slot_we = 1'b1; slot_idx = 3'd1; slot_sprite = 3'd3; slot_en = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (slot_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_commit_ready: got %b want 1", slot_ready);
        end
        slot_idx = 3'd2; slot_sprite = 3'd1;
        @(posedge clk); #1;
        n_tests++;
        if (out_vsync !== 1'b1) begin
            n_fail++; $display("FAIL vsync_delay: got %b want 1", out_vsync);
        end
        slot_we = 1'b0; pix_vsync = 1'b0;
        run_pixel(10'd196, 10'd204, a, c, act, hs);
        n_tests++;
        if (a !== 9'd0 || c !== 12'h000) begin
            n_fail++; $display("FAIL slot2_pending: addr=%0d rgb=%h want 0 000", a, c);
        end
        pulse_vsync();
        run_pixel(10'd196, 10'd204, a, c, act, hs);
        n_tests++;
        if (a !== 9'd73 || c !== 12'hFFF) begin
            n_fail++; $display("FAIL slot2_shown: addr=%0d rgb=%h want 73 fff", a, c);
        end
        run_pixel(10'd132, 10'd204, a, c, act, hs);
        n_tests++;
        if (a !== 9'd0 || c !== 12'h000) begin
            n_fail++; $display("FAIL slot1_ignored: addr=%0d rgb=%h want 0 000", a, c);
        end
    endtask

    task automatic test_border();
        logic [8:0] a; logic [11:0] c; logic act, hs;
        run_pixel(10'd64, 10'd200, a, c, act, hs);
        n_tests++;
        if (c !== EDGE_FG) begin
            n_fail++; $display("FAIL border_corner: rgb=%h want %h", c, EDGE_FG);
        end
        run_pixel(10'd68, 10'd204, a, c, act, hs);
        n_tests++;
        if (a !== 9'd137 || c !== 12'hFFF) begin
            n_fail++; $display("FAIL inner_set: addr=%0d rgb=%h want 137 fff", a, c);
        end
        run_pixel(10'd72, 10'd208, a, c, act, hs);
        n_tests++;
        if (a !== 9'd146 || c !== 12'h000) begin
            n_fail++; $display("FAIL inner_clear: addr=%0d rgb=%h want 146 000", a, c);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem_bits[i] = 1'b0;
        // address 0 set so a miss that leaks mem_data shows up as FG
        mem_bits[0]   = 1'b1;
        mem_bits[73]  = 1'b1;
        mem_bits[128] = 1'b1;
        mem_bits[135] = 1'b1;
        mem_bits[137] = 1'b1;
        mem_bits[171] = 1'b1;
        mem_bits[201] = 1'b1;
        pix_x = '0; pix_y = '0; pix_active = 1'b0; pix_hsync = 1'b0; pix_vsync = 1'b0;
        slot_we = 1'b0; slot_idx = '0; slot_sprite = '0; slot_en = 1'b0;
        test_reset();
        test_slot_write();
        test_column_edge();
        test_boundaries();
        test_commit_write();
        test_border();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
